// File: rtl/mdu_pkg.sv
// Shared types and helpers for the M-extension issue/writeback controller.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_funct3_e;

  localparam logic WB_SEL_MUL = 1'b0;
  localparam logic WB_SEL_DIV = 1'b1;

  typedef struct packed {
    logic       valid;
    logic [2:0] op;
    logic [4:0] rd;
  } mdu_slot_t;

  localparam int SLOT_W = $bits(mdu_slot_t);

  function automatic logic is_div_op(input logic [2:0] op);
    return (op >= MDU_DIV);
  endfunction

  // A used, nonzero source register that names the given destination.
  function automatic logic src_hit(input logic use_src, input logic [4:0] rs,
                                   input logic [4:0] rd);
    return use_src && (rs != 5'd0) && (rs == rd);
  endfunction

endpackage

// File: rtl/mdu_slot_reg.sv
// One multiplier pipeline slot: kill clears, hold keeps, otherwise loads.
module mdu_slot_reg
  import mdu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_hold,
  input  logic              i_kill,
  input  logic [SLOT_W-1:0] i_d,
  output logic [SLOT_W-1:0] o_q
);

  logic [SLOT_W-1:0] r_slot;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_slot <= '0;
    end else if (i_kill) begin
      r_slot <= '0;
    end else if (!i_hold) begin
      r_slot <= i_d;
    end
  end

  assign o_q = r_slot;

endmodule

// File: rtl/mdu_issue_ctrl.sv
// M-unit issue, hazard and writeback control for the E/M/W multiplier and the
// iterative divider. Divider sequencing is compiled in only with MDU_DIV_EN.
module mdu_issue_ctrl
  import mdu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dec_m_valid,
  input  logic [2:0] dec_funct3,
  input  logic [4:0] dec_rd,
  input  logic [4:0] dec_rs1,
  input  logic [4:0] dec_rs2,
  input  logic       dec_use_rs1,
  input  logic       dec_use_rs2,
  input  logic       pipe_stall,
  input  logic       flush,
  input  logic       div_busy,
  input  logic       div_done,
  output logic       stall_req,
  output logic [1:0] mul_op_e,
  output logic [1:0] mul_op_w,
  output logic       mul_v_e,
  output logic       mul_v_m,
  output logic       mul_v_w,
  output logic       div_start,
  output logic [1:0] div_op,
  output logic       div_ack,
  output logic       wb_valid,
  output logic [4:0] wb_rd,
  output logic       wb_sel,
  output logic       illegal
);

  logic [SLOT_W-1:0] w_slot_d    [3];
  logic [SLOT_W-1:0] w_slot_q    [3];
  logic              w_slot_kill [3];
  mdu_slot_t         w_slot      [3];

  logic       w_issue;
  logic       w_dec_div;
  logic       w_dec_legal;
  logic       w_e_mul;
  logic       w_e_div;
  logic       w_e_to_m;
  logic       w_raw_mul;
  logic       w_raw_div;
  logic       w_struct;
  logic       w_starve;
  logic       w_div_wb;
  logic [4:0] w_div_rd;
  logic       w_unused;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_slot
      mdu_slot_reg u_slot (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_hold (pipe_stall),
        .i_kill (w_slot_kill[gi]),
        .i_d    (w_slot_d[gi]),
        .o_q    (w_slot_q[gi])
      );
      assign w_slot[gi] = mdu_slot_t'(w_slot_q[gi]);
    end
  endgenerate

  assign w_dec_div = is_div_op(dec_funct3);
  assign w_e_mul   = w_slot[0].valid && !is_div_op(w_slot[0].op);
  assign w_e_div   = w_slot[0].valid && is_div_op(w_slot[0].op);
  assign w_e_to_m  = w_e_mul && !flush;

  // A stalled flush must still empty E; an unstalled one simply skips the E->M move.
  assign w_slot_kill[0] = flush && pipe_stall;
  assign w_slot_kill[1] = 1'b0;
  assign w_slot_kill[2] = 1'b0;

  assign w_issue     = dec_m_valid && !stall_req && !pipe_stall && w_dec_legal;
  assign w_slot_d[0] = w_issue ? {1'b1, dec_funct3, dec_rd} : '0;
  assign w_slot_d[1] = w_e_to_m ? w_slot_q[0] : '0;
  assign w_slot_d[2] = w_slot_q[1];

  // W is bypassed by the register file, so only E and M results can be RAW hazards.
  assign w_raw_mul =
      (w_e_mul && (src_hit(dec_use_rs1, dec_rs1, w_slot[0].rd) ||
                   src_hit(dec_use_rs2, dec_rs2, w_slot[0].rd))) ||
      (w_slot[1].valid && (src_hit(dec_use_rs1, dec_rs1, w_slot[1].rd) ||
                           src_hit(dec_use_rs2, dec_rs2, w_slot[1].rd)));

`ifdef MDU_DIV_EN
  logic       r_div_pend;
  logic [4:0] r_div_rd;
  logic       w_div_start;

  assign w_div_start = w_e_div && !flush && !pipe_stall;
  assign w_div_wb    = !w_slot[2].valid && div_done && r_div_pend;
  assign w_div_rd    = r_div_rd;
  assign w_raw_div   = r_div_pend && (src_hit(dec_use_rs1, dec_rs1, r_div_rd) ||
                                      src_hit(dec_use_rs2, dec_rs2, r_div_rd));
  assign w_struct    = dec_m_valid && w_dec_div && (r_div_pend || w_e_div);
  assign w_starve    = dec_m_valid && !w_dec_div && div_done && r_div_pend;
  assign w_dec_legal = 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_pend <= 1'b0;
      r_div_rd   <= 5'd0;
    end else if (!pipe_stall) begin
      if (w_div_start) begin
        r_div_pend <= 1'b1;
        r_div_rd   <= w_slot[0].rd;
      end else if (w_div_wb) begin
        r_div_pend <= 1'b0;
      end
    end
  end

  assign div_start = w_div_start;
  assign div_op    = w_div_start ? w_slot[0].op[1:0] : 2'd0;
  assign div_ack   = w_div_wb && !pipe_stall;
  assign illegal   = 1'b0;
  assign w_unused  = ^{div_busy, w_slot[1], w_slot[2]};
`else
  assign w_div_wb    = 1'b0;
  assign w_div_rd    = 5'd0;
  assign w_raw_div   = 1'b0;
  assign w_struct    = 1'b0;
  assign w_starve    = 1'b0;
  assign w_dec_legal = !w_dec_div;
  assign div_start   = 1'b0;
  assign div_op      = 2'd0;
  assign div_ack     = 1'b0;
  assign illegal     = dec_m_valid && w_dec_div;
  assign w_unused    = ^{div_busy, div_done, w_e_div, w_slot[1], w_slot[2]};
`endif

  assign stall_req = w_raw_mul || w_raw_div || w_struct || w_starve;

  assign mul_v_e  = w_e_mul;
  assign mul_op_e = w_e_mul ? w_slot[0].op[1:0] : 2'd0;
  assign mul_v_m  = w_slot[1].valid;
  assign mul_v_w  = w_slot[2].valid;
  assign mul_op_w = w_slot[2].op[1:0];

  // wb_rd/wb_sel keep showing the selected source during a stall; only wb_valid is masked.
  assign wb_valid = !pipe_stall && (w_slot[2].valid || w_div_wb);
  assign wb_sel   = w_div_wb ? WB_SEL_DIV : WB_SEL_MUL;
  assign wb_rd    = w_slot[2].valid ? w_slot[2].rd : (w_div_wb ? w_div_rd : 5'd0);

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Self-checking bench for mdu_issue_ctrl: queue-based model plus directed literal checks.
module tb_mdu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dec_m_valid, dec_use_rs1, dec_use_rs2, pipe_stall, flush;
  logic [2:0] dec_funct3;
  logic [4:0] dec_rd, dec_rs1, dec_rs2;
  logic       div_busy = 1'b0, div_done = 1'b0;
  logic       stall_req, mul_v_e, mul_v_m, mul_v_w, div_start, div_ack;
  logic       wb_valid, wb_sel, illegal;
  logic [1:0] mul_op_e, mul_op_w, div_op;
  logic [4:0] wb_rd;

  int errors = 0;
  int checks = 0;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  mdu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .dec_m_valid(dec_m_valid), .dec_funct3(dec_funct3),
    .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use_rs1(dec_use_rs1),
    .dec_use_rs2(dec_use_rs2), .pipe_stall(pipe_stall), .flush(flush),
    .div_busy(div_busy), .div_done(div_done), .stall_req(stall_req),
    .mul_op_e(mul_op_e), .mul_op_w(mul_op_w), .mul_v_e(mul_v_e), .mul_v_m(mul_v_m),
    .mul_v_w(mul_v_w), .div_start(div_start), .div_op(div_op), .div_ack(div_ack),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_sel(wb_sel), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Model: every in-flight op with its age (0 = just issued, 1, 2 = writeback cycle).
  typedef struct {
    logic [4:0] rd;
    logic [2:0] f3;
    int         age;
  } op_t;

  op_t        q[$];
  op_t        nq[$];
  bit         dpend = 1'b0;
  logic [4:0] drd = 5'd0;
  bit         armed = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit hit(input logic u, input logic [4:0] rs, input logic [4:0] rd);
    return u && (rs != 5'd0) && (rs == rd);
  endfunction

  function automatic int idx(input int age);
    foreach (q[i]) if (q[i].age == age) return i;
    return -1;
  endfunction

  function automatic bit exp_stall();
    bit s = 1'b0;
    foreach (q[i])
      if (q[i].f3 < 3'd4 && q[i].age < 2 &&
          (hit(dec_use_rs1, dec_rs1, q[i].rd) || hit(dec_use_rs2, dec_rs2, q[i].rd)))
        s = 1'b1;
    if (DIV_EN) begin
      if (dpend && (hit(dec_use_rs1, dec_rs1, drd) || hit(dec_use_rs2, dec_rs2, drd)))
        s = 1'b1;
      if (dec_m_valid && dec_funct3 >= 3'd4) begin
        if (dpend) s = 1'b1;
        foreach (q[i]) if (q[i].age == 0 && q[i].f3 >= 3'd4) s = 1'b1;
      end
      if (dec_m_valid && dec_funct3 < 3'd4 && div_done && dpend) s = 1'b1;
    end
    return s;
  endfunction

  bit m_issue, m_ack;
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      dpend = 1'b0;
      drd   = 5'd0;
      armed = 1'b1;
    end else if (armed) begin
      m_issue = dec_m_valid && !exp_stall() && !pipe_stall && (DIV_EN || dec_funct3 < 3'd4);
      if (pipe_stall) begin
        if (flush) begin
          nq.delete();
          foreach (q[i]) if (q[i].age != 0) nq.push_back(q[i]);
          q = nq;
        end
      end else begin
        m_ack = DIV_EN && idx(2) < 0 && div_done && dpend;
        if (m_ack) dpend = 1'b0;
        nq.delete();
        foreach (q[i]) begin
          if (q[i].age == 0 && !flush) begin
            if (q[i].f3 >= 3'd4) begin
              dpend = 1'b1;
              drd   = q[i].rd;
            end else begin
              nq.push_back('{rd: q[i].rd, f3: q[i].f3, age: 1});
            end
          end else if (q[i].age == 1) begin
            nq.push_back('{rd: q[i].rd, f3: q[i].f3, age: 2});
          end
        end
        q = nq;
        if (m_issue) q.push_back('{rd: dec_rd, f3: dec_funct3, age: 0});
      end
    end
  end

  int ei, mi, wi;
  bit e_mul, e_go, dwb;
  always @(negedge clk) begin
    if (armed) begin
      ei    = idx(0);
      mi    = idx(1);
      wi    = idx(2);
      e_mul = (ei >= 0) && (q[ei].f3 < 3'd4);
      e_go  = DIV_EN && (ei >= 0) && (q[ei].f3 >= 3'd4) && !flush && !pipe_stall;
      dwb   = DIV_EN && (wi < 0) && div_done && dpend;
      chk("stall_req", int'(stall_req), int'(exp_stall()));
      chk("mul_v_e", int'(mul_v_e), int'(e_mul));
      chk("mul_op_e", int'(mul_op_e), e_mul ? int'(q[ei].f3[1:0]) : 0);
      chk("mul_v_m", int'(mul_v_m), int'(mi >= 0));
      chk("mul_v_w", int'(mul_v_w), int'(wi >= 0));
      chk("mul_op_w", int'(mul_op_w), (wi >= 0) ? int'(q[wi].f3[1:0]) : 0);
      chk("wb_valid", int'(wb_valid), int'(!pipe_stall && (wi >= 0 || dwb)));
      chk("wb_rd", int'(wb_rd), (wi >= 0) ? int'(q[wi].rd) : (dwb ? int'(drd) : 0));
      chk("wb_sel", int'(wb_sel), int'(dwb));
      chk("div_start", int'(div_start), int'(e_go));
      chk("div_op", int'(div_op), e_go ? int'(q[ei].f3[1:0]) : 0);
      chk("div_ack", int'(div_ack), int'(dwb && !pipe_stall));
      chk("illegal", int'(illegal), int'(!DIV_EN && dec_m_valid && dec_funct3 >= 3'd4));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_m_valid = 1'b0; dec_funct3 = 3'd0; dec_rd = 5'd0;
    dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0;
    pipe_stall = 1'b0; flush = 1'b0;
  endtask

  task automatic mop(input logic [2:0] f3, input logic [4:0] rd);
    idle();
    dec_m_valid = 1'b1; dec_funct3 = f3; dec_rd = rd;
  endtask

  initial begin
    idle();
    repeat (2) cyc();
    @(negedge clk);
    $display("test: reset");
    chk("rst.stall_req", int'(stall_req), 0);
    chk("rst.mul_v_w", int'(mul_v_w), 0);
    chk("rst.wb_valid", int'(wb_valid), 0);
    chk("rst.div_start", int'(div_start), 0);
    cyc(); rst_n = 1'b1;

    $display("test: MUL x5 then dependent ADD");
    cyc(); mop(3'd0, 5'd5);
    @(negedge clk); chk("A.stall_c0", int'(stall_req), 0);
    cyc(); idle(); dec_rs1 = 5'd5; dec_use_rs1 = 1'b1;
    @(negedge clk); chk("A.stall_c1", int'(stall_req), 1);
    cyc();
    @(negedge clk); chk("A.stall_c2", int'(stall_req), 1);
    cyc();
    @(negedge clk);
    chk("A.stall_c3", int'(stall_req), 0);
    chk("A.wb_valid", int'(wb_valid), 1);
    chk("A.wb_rd", int'(wb_rd), 5);
    chk("A.wb_sel", int'(wb_sel), 0);
    cyc(); idle();

    $display("test: x0 and rs2 hazards");
    cyc(); mop(3'd0, 5'd0);
    cyc(); idle(); dec_use_rs1 = 1'b1;
    @(negedge clk); chk("B.x0_stall", int'(stall_req), 0);
    cyc(); mop(3'd2, 5'd9);
    cyc(); idle(); dec_rs2 = 5'd9; dec_use_rs2 = 1'b1;
    @(negedge clk); chk("B.rs2_stall", int'(stall_req), 1);
    cyc(); idle(); dec_rs2 = 5'd9;
    @(negedge clk); chk("B.unused_rs2", int'(stall_req), 0);
    repeat (2) cyc();

    $display("test: pipe_stall with E/M/W occupied");
    cyc(); mop(3'd1, 5'd1);
    cyc(); mop(3'd2, 5'd2);
    cyc(); mop(3'd3, 5'd3);
    for (int k = 0; k < 4; k++) begin
      cyc(); idle(); pipe_stall = 1'b1;
      @(negedge clk);
      chk("C.hold_wb_valid", int'(wb_valid), 0);
      chk("C.hold_wb_rd", int'(wb_rd), 1);
      chk("C.hold_op_w", int'(mul_op_w), 1);
      chk("C.hold_v_e", int'(mul_v_e), 1);
    end
    for (int k = 1; k <= 3; k++) begin
      cyc(); idle();
      @(negedge clk);
      chk("C.rel_wb_valid", int'(wb_valid), 1);
      chk("C.rel_wb_rd", int'(wb_rd), k);
      chk("C.rel_op_w", int'(mul_op_w), k);
    end
    cyc(); idle();

    $display("test: flush");
    cyc(); mop(3'd0, 5'd4);
    cyc(); idle(); flush = 1'b1;
    @(negedge clk); chk("D.v_e_before", int'(mul_v_e), 1);
    cyc(); idle();
    @(negedge clk); chk("D.v_m_killed", int'(mul_v_m), 0);
    cyc();
    @(negedge clk); chk("D.no_wb", int'(wb_valid), 0);
    cyc(); mop(3'd0, 5'd6);
    cyc(); idle(); flush = 1'b1; pipe_stall = 1'b1;
    cyc(); idle();
    @(negedge clk); chk("D.stallflush_v_e", int'(mul_v_e), 0);
    cyc();
    @(negedge clk); chk("D.stallflush_v_m", int'(mul_v_m), 0);
    repeat (2) cyc();

`ifdef MDU_DIV_EN
    $display("test: DIVU x7 full sequence");
    cyc(); mop(3'd5, 5'd7);
    @(negedge clk); chk("F.stall_issue", int'(stall_req), 0);
    cyc(); idle(); div_busy = 1'b1;
    @(negedge clk);
    chk("F.div_start", int'(div_start), 1);
    chk("F.div_op", int'(div_op), 1);
    cyc(); mop(3'd4, 5'd15);
    @(negedge clk); chk("F.struct_stall", int'(stall_req), 1);
    cyc(); idle(); dec_rs1 = 5'd7; dec_use_rs1 = 1'b1;
    @(negedge clk); chk("F.raw_div_stall", int'(stall_req), 1);
    repeat (30) begin cyc(); idle(); end
    cyc(); div_busy = 1'b0; div_done = 1'b1;
    @(negedge clk);
    chk("F.div_ack", int'(div_ack), 1);
    chk("F.wb_valid", int'(wb_valid), 1);
    chk("F.wb_rd", int'(wb_rd), 7);
    chk("F.wb_sel", int'(wb_sel), 1);
    cyc(); div_done = 1'b0;
    @(negedge clk);
    chk("F.ack_once", int'(div_ack), 0);
    chk("F.wb_once", int'(wb_valid), 0);

    $display("test: div_done while MUL x3 in W");
    cyc(); mop(3'd4, 5'd10);
    cyc(); idle();
    cyc(); mop(3'd0, 5'd3);
    cyc(); idle();
    cyc(); idle();
    cyc(); mop(3'd0, 5'd11); div_done = 1'b1;
    @(negedge clk);
    chk("G.mul_first_rd", int'(wb_rd), 3);
    chk("G.mul_first_sel", int'(wb_sel), 0);
    chk("G.no_ack_yet", int'(div_ack), 0);
    chk("G.starve_stall", int'(stall_req), 1);
    cyc();
    @(negedge clk);
    chk("G.div_rd", int'(wb_rd), 10);
    chk("G.div_sel", int'(wb_sel), 1);
    chk("G.div_ack", int'(div_ack), 1);
    chk("G.starve_stall2", int'(stall_req), 1);
    cyc(); div_done = 1'b0;
    @(negedge clk); chk("G.mul_released", int'(stall_req), 0);
    cyc(); idle();
    repeat (3) cyc();

    $display("test: flushed DIV and reset mid-divide");
    cyc(); mop(3'd4, 5'd12);
    cyc(); idle(); flush = 1'b1;
    @(negedge clk); chk("H.no_start", int'(div_start), 0);
    cyc(); mop(3'd6, 5'd13);
    @(negedge clk); chk("H.no_stall", int'(stall_req), 0);
    cyc(); idle();
    @(negedge clk);
    chk("H.start_rem", int'(div_start), 1);
    chk("H.op_rem", int'(div_op), 2);
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1; div_done = 1'b1; mop(3'd4, 5'd14);
    @(negedge clk);
    chk("H.late_done_ack", int'(div_ack), 0);
    chk("H.late_done_wb", int'(wb_valid), 0);
    chk("H.post_rst_stall", int'(stall_req), 0);
    cyc(); idle(); div_done = 1'b0;
    @(negedge clk); chk("H.start_after_rst", int'(div_start), 1);
    cyc(); div_done = 1'b1;
    @(negedge clk);
    chk("H.ack14", int'(div_ack), 1);
    chk("H.rd14", int'(wb_rd), 14);
    cyc(); div_done = 1'b0;
`else
    $display("test: REM with divider compiled out");
    cyc(); mop(3'd6, 5'd8);
    @(negedge clk);
    chk("E.illegal", int'(illegal), 1);
    chk("E.stall", int'(stall_req), 0);
    cyc(); idle(); dec_funct3 = 3'd6;
    @(negedge clk);
    chk("E.not_issued", int'(mul_v_e), 0);
    chk("E.no_start", int'(div_start), 0);
    chk("E.illegal_novalid", int'(illegal), 0);
    cyc(); mop(3'd7, 5'd9); div_done = 1'b1;
    @(negedge clk);
    chk("E.remu_illegal", int'(illegal), 1);
    chk("E.no_ack", int'(div_ack), 0);
    cyc(); idle(); div_done = 1'b0;
    @(negedge clk); chk("E.no_start2", int'(div_start), 0);
`endif

    repeat (3) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
